// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    // Five sequencer states need three bits of encoding.
    localparam logic [2:0] PCTL_RUN_ENC   = 3'd0;
    localparam logic [2:0] PCTL_HAZ_ENC   = 3'd1;
    localparam logic [2:0] PCTL_MEMW_ENC  = 3'd2;
    localparam logic [2:0] PCTL_FLUSH_ENC = 3'd3;
    localparam logic [2:0] PCTL_ERR_ENC   = 3'd4;

    typedef enum logic [2:0] {
        PCTL_RUN   = PCTL_RUN_ENC,
        PCTL_HAZ   = PCTL_HAZ_ENC,
        PCTL_MEMW  = PCTL_MEMW_ENC,
        PCTL_FLUSH = PCTL_FLUSH_ENC,
        PCTL_ERR   = PCTL_ERR_ENC
    } pctl_state_t;

    // Freeze/flush bundle for top-level wiring.
    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic id_ex_freeze;
        logic ex_mem_freeze;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pctl_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush statistics.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Arbitrates memory wait, branch flush and data-hazard stall into
// per-register freeze/flush controls, with a memory-wait watchdog.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned STALL_W = 32,
    parameter int unsigned FLUSH_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_detected,
    input  logic               branch_taken,
    input  logic               mem_req,
    input  logic               sram_ready,
    output logic               pc_freeze,
    output logic               if_id_freeze,
    output logic               id_ex_freeze,
    output logic               ex_mem_freeze,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               mem_wb_flush,
    output logic               wd_error,
    output logic [STALL_W-1:0] stall_cycles,
    output logic [FLUSH_W-1:0] flush_count
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT) + 1;

    pctl_state_t       state;
    pctl_state_t       state_nxt;
    pctl_ctrl_t        ctrl;
    logic [WCNT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              wd_trip;
    logic              flush_evt;

    assign mem_wait = mem_req & ~sram_ready;
    assign wd_trip  = mem_wait && (wait_cnt == WCNT_W'(TIMEOUT - 1));

    // Priority decode: ERR > memory wait > branch flush > hazard > run.
    always_comb begin
        ctrl      = '0;
        state_nxt = PCTL_RUN;
        flush_evt = 1'b0;
        if (state == PCTL_ERR) begin
            ctrl.pc_freeze     = 1'b1;
            ctrl.if_id_freeze  = 1'b1;
            ctrl.id_ex_freeze  = 1'b1;
            ctrl.ex_mem_freeze = 1'b1;
            ctrl.mem_wb_flush  = 1'b1;
            state_nxt          = PCTL_ERR;
        end else if (mem_wait) begin
            // A branch held in EXE during the wait is flushed once memory releases.
            ctrl.pc_freeze     = 1'b1;
            ctrl.if_id_freeze  = 1'b1;
            ctrl.id_ex_freeze  = 1'b1;
            ctrl.ex_mem_freeze = 1'b1;
            ctrl.mem_wb_flush  = 1'b1;
            state_nxt          = wd_trip ? PCTL_ERR : PCTL_MEMW;
        end else if (branch_taken) begin
            // Any hazard now is on the wrong path and is dropped.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            flush_evt        = 1'b1;
            state_nxt        = PCTL_FLUSH;
        end else if (hazard_detected) begin
            ctrl.pc_freeze    = 1'b1;
            ctrl.if_id_freeze = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            state_nxt         = PCTL_HAZ;
        end
    end

    // State, watchdog wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PCTL_RUN;
            wait_cnt <= '0;
            wd_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            wd_error <= wd_error | (state_nxt == PCTL_ERR);
            if (mem_wait && (state != PCTL_ERR)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else if (!mem_wait) begin
                wait_cnt <= '0;
            end
        end
    end

    assign pc_freeze     = ctrl.pc_freeze;
    assign if_id_freeze  = ctrl.if_id_freeze;
    assign id_ex_freeze  = ctrl.id_ex_freeze;
    assign ex_mem_freeze = ctrl.ex_mem_freeze;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign mem_wb_flush  = ctrl.mem_wb_flush;

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.pc_freeze | ctrl.ex_mem_freeze),
        .count (stall_cycles)
    );

    sat_counter #(.W(FLUSH_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_evt),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: vector table for the single-cycle decode plus
// hand-written multi-cycle sequences (wait, watchdog, saturation).
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst;
    logic hazard_detected, branch_taken, mem_req, sram_ready;

    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic        a_pc, a_ifidfz, a_idexfz, a_exmemfz, a_ifidfl, a_idexfl, a_memwbfl, a_wd;
    logic [31:0] a_stall;
    logic [15:0] a_flush;
    // Instance B: short watchdog, narrow flush counter.
    logic        b_pc, b_ifidfz, b_idexfz, b_exmemfz, b_ifidfl, b_idexfl, b_memwbfl, b_wd;
    logic [7:0]  b_stall;
    logic [1:0]  b_flush;

    pipeline_stall_controller dut_a (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready),
        .pc_freeze(a_pc), .if_id_freeze(a_ifidfz), .id_ex_freeze(a_idexfz), .ex_mem_freeze(a_exmemfz),
        .if_id_flush(a_ifidfl), .id_ex_flush(a_idexfl), .mem_wb_flush(a_memwbfl),
        .wd_error(a_wd), .stall_cycles(a_stall), .flush_count(a_flush)
    );

    pipeline_stall_controller #(.TIMEOUT(4), .STALL_W(8), .FLUSH_W(2)) dut_b (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready),
        .pc_freeze(b_pc), .if_id_freeze(b_ifidfz), .id_ex_freeze(b_idexfz), .ex_mem_freeze(b_exmemfz),
        .if_id_flush(b_ifidfl), .id_ex_flush(b_idexfl), .mem_wb_flush(b_memwbfl),
        .wd_error(b_wd), .stall_cycles(b_stall), .flush_count(b_flush)
    );

    // {pc_fz, if_id_fz, id_ex_fz, ex_mem_fz, if_id_fl, id_ex_fl, mem_wb_fl}
    logic [6:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_pc, a_ifidfz, a_idexfz, a_exmemfz, a_ifidfl, a_idexfl, a_memwbfl};
    assign b_ctrl = {b_pc, b_ifidfz, b_idexfz, b_exmemfz, b_ifidfl, b_idexfl, b_memwbfl};

    localparam logic [6:0] C_RUN   = 7'b0000000;
    localparam logic [6:0] C_HAZ   = 7'b1100010;
    localparam logic [6:0] C_FLUSH = 7'b0000110;
    localparam logic [6:0] C_MEMW  = 7'b1111001;

    typedef struct {
        logic       h, b, m, r;
        logic [6:0] exp_ctrl;
    } vec_t;

    vec_t vecs[10];
    int n_cmp  = 0;
    int n_fail = 0;
    int exp_stall, exp_flush;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; inputs settle, then combinational outputs are stable.
    task automatic apply(input logic h, input logic b, input logic m, input logic r);
        hazard_detected = h;
        branch_taken    = b;
        mem_req         = m;
        sram_ready      = r;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        apply(0, 0, 0, 0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        hazard_detected = 0; branch_taken = 0; mem_req = 0; sram_ready = 0;
        @(negedge clk);
        do_reset();

        // Reset state
        apply(0, 0, 0, 0);
        chk("reset_ctrl", a_ctrl, C_RUN);
        chk("reset_stall", a_stall, 0);
        chk("reset_flush", a_flush, 0);
        chk("reset_wd", a_wd, 0);

        // Single-cycle decode table from RUN
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, C_HAZ};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, C_MEMW};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, C_MEMW};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, C_RUN};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, C_HAZ};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, C_FLUSH};
        vecs[9] = '{1'b0, 1'b0, 0, 1'b1, C_RUN};
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].h, vecs[i].b, vecs[i].m, vecs[i].r);
            chk($sformatf("vec%0d_ctrl", i), a_ctrl, vecs[i].exp_ctrl);
            if (vecs[i].exp_ctrl == C_HAZ || vecs[i].exp_ctrl == C_MEMW) exp_stall++;
            if (vecs[i].exp_ctrl == C_FLUSH) exp_flush++;
            next_cycle();
        end
        apply(0, 0, 0, 0);
        chk("vec_stall", a_stall, 64'(exp_stall));
        chk("vec_flush", a_flush, 64'(exp_flush));

        // Hazard only, 2 cycles
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, 0);
            chk("haz_ctrl", a_ctrl, C_HAZ);
            next_cycle();
        end
        apply(0, 0, 0, 0);
        chk("haz_release", a_ctrl, C_RUN);
        chk("haz_stall", a_stall, 2);

        // Branch plus hazard
        do_reset();
        apply(1, 1, 0, 0);
        chk("brhaz_ctrl", a_ctrl, C_FLUSH);
        next_cycle();
        apply(0, 0, 0, 0);
        chk("brhaz_flush", a_flush, 1);
        chk("brhaz_stall", a_stall, 0);

        // Memory wait 5 cycles then ready
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 0);
            chk("memw_ctrl", a_ctrl, C_MEMW);
            next_cycle();
        end
        apply(0, 0, 1, 1);
        chk("memw_ready", a_ctrl, C_RUN);
        next_cycle();
        apply(0, 0, 0, 0);
        chk("memw_stall", a_stall, 5);

        // Branch held during 3 wait cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 1, 0);
            chk("brw_ctrl", a_ctrl, C_MEMW);
            next_cycle();
        end
        apply(0, 1, 1, 1);
        chk("brw_flush_on_ready", a_ctrl, C_FLUSH);
        next_cycle();
        apply(0, 0, 0, 0);
        chk("brw_flush_cnt", a_flush, 1);
        chk("brw_stall", a_stall, 3);

        // Reset in the middle of a wait
        do_reset();
        apply(0, 0, 1, 0);
        next_cycle();
        next_cycle();
        #2 rst = 1'b0;
        #1;
        chk("rstmid_ctrl", a_ctrl, C_MEMW);
        chk("rstmid_stall", a_stall, 0);
        next_cycle();
        rst = 1'b1;

        // Watchdog, TIMEOUT=4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 0);
            chk("wd_wait_ctrl", b_ctrl, C_MEMW);
            chk("wd_not_yet", b_wd, 0);
            next_cycle();
        end
        apply(0, 0, 0, 0);
        chk("wd_tripped", b_wd, 1);
        chk("wd_err_ctrl", b_ctrl, C_MEMW);
        chk("wd_a_clean", a_wd, 0);
        next_cycle();
        apply(0, 1, 0, 0);
        chk("wd_absorb", b_ctrl, C_MEMW);
        chk("wd_stall", b_stall, 5);
        #2 rst = 1'b0;
        #1;
        chk("wd_rst_wd", b_wd, 0);
        chk("wd_rst_ctrl", b_ctrl, C_FLUSH);
        chk("wd_rst_stall", b_stall, 0);
        next_cycle();
        rst = 1'b1;

        // Back-to-back waits split by a ready cycle restart the count
        do_reset();
        for (int i = 0; i < 3; i++) begin apply(0, 0, 1, 0); next_cycle(); end
        apply(0, 0, 1, 1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin apply(0, 0, 1, 0); next_cycle(); end
        apply(0, 0, 0, 0);
        chk("wd_restart", b_wd, 0);
        chk("wd_restart_ctrl", b_ctrl, C_RUN);

        // Flush counter saturation, FLUSH_W=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 0);
            next_cycle();
            #1;
            chk($sformatf("sat_flush%0d", i), b_flush, (i + 1 > 3) ? 3 : i + 1);
        end
        apply(0, 0, 0, 0);
        next_cycle();
        chk("sat_hold", b_flush, 3);
        chk("sat_wide", a_flush, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
